rename_regfile_ckpt: RTL

- Parametrised architectural register file with a rename-tag table for the out-of-order core, plus branch checkpoints of the tag table.
- Decoder writes destination tags, the ROB commits data and clears matching tags, and NUM_RD combinational read ports return data and tag with commit bypass.
- Holds NUM_CKPT snapshots of the tag table. A mispredict restores one snapshot in a single cycle; a full flush frees every tag.

---
 rtl/rename_regfile_ckpt.sv | 97 +++++++++
 1 files changed

// File: rtl/rename_regfile_ckpt.sv
// rename_regfile_ckpt: architectural register file with rename-tag table and branch checkpoints
module rename_regfile_ckpt #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter int TAG_W = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = '0,
  parameter int NUM_RD = 3,
  parameter int NUM_CKPT = 4,
  localparam int CK_W = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cm_en,
  input  logic [REG_W-1:0]         cm_name,
  input  logic [DATA_W-1:0]        cm_data,
  input  logic [TAG_W-1:0]         cm_tag,
  input  logic                     rn_en,
  input  logic [REG_W-1:0]         rn_name,
  input  logic [TAG_W-1:0]         rn_tag,
  input  logic [NUM_RD*REG_W-1:0]  rd_name,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag,
  input  logic                     ck_en,
  output logic [CK_W-1:0]          ck_id,
  output logic                     ck_full,
  input  logic                     ck_rel_en,
  input  logic [CK_W-1:0]          ck_rel_id,
  input  logic                     rs_en,
  input  logic [CK_W-1:0]          rs_id,
  input  logic [NUM_CKPT-1:0]      rs_kill,
  input  logic                     flush
);
  localparam int REG_CNT = 1 << REG_W;
  logic [REG_CNT-1:0][DATA_W-1:0] data_q, data_d;
  logic [REG_CNT-1:0][TAG_W-1:0] tag_q, tag_d, tag_rn;
  logic [NUM_CKPT-1:0][REG_CNT-1:0][TAG_W-1:0] snap_q, snap_d, snap_clr;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [NUM_RD-1:0][REG_W-1:0] rd_n;
  logic cm_hit, rn_hit, rs_ok, ck_take;
  assign cm_hit = cm_en && cm_name != '0;
  assign rn_hit = rn_en && rn_name != '0;
  assign rs_ok = rs_en && valid_q[rs_id];
  assign ck_take = ck_en && !ck_full && !flush && !rs_ok;
  assign ck_full = &valid_q;
  assign rd_n = rd_name;
  // lowest-index free checkpoint slot
  always_comb begin
    ck_id = '0;
    for (int i = NUM_CKPT - 1; i >= 0; i--)
      if (!valid_q[i]) ck_id = CK_W'(i);
  end
  // read ports: register 0 hardwired, otherwise commit data and tag clear bypass the stored copy
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic byp;
    assign byp = cm_en && cm_name == rd_n[p];
    assign rd_data[p*DATA_W +: DATA_W] = rd_n[p] == '0 ? '0 : byp ? cm_data : data_q[rd_n[p]];
    assign rd_tag[p*TAG_W +: TAG_W] = rd_n[p] == '0 ? TAG_FREE :
                                      (byp && tag_q[rd_n[p]] == cm_tag) ? TAG_FREE : tag_q[rd_n[p]];
  end
  // commit clears matching tags in the live table and every valid snapshot; rename overrides commit
  always_comb begin
    tag_rn = tag_q;
    if (cm_hit && tag_q[cm_name] == cm_tag) tag_rn[cm_name] = TAG_FREE;
    if (rn_hit) tag_rn[rn_name] = rn_tag;
    snap_clr = snap_q;
    for (int i = 0; i < NUM_CKPT; i++)
      if (cm_hit && valid_q[i] && snap_q[i][cm_name] == cm_tag) snap_clr[i][cm_name] = TAG_FREE;
  end
  // next state: flush beats restore beats rename/checkpoint; release always applies
  always_comb begin
    data_d = data_q;
    if (cm_hit) data_d[cm_name] = cm_data;
    tag_d = flush ? {REG_CNT{TAG_FREE}} : rs_ok ? snap_clr[rs_id] : tag_rn;
    snap_d = snap_clr;
    if (ck_take) snap_d[ck_id] = tag_rn;
    valid_d = valid_q;
    if (ck_rel_en) valid_d[ck_rel_id] = 1'b0;
    if (rs_en) valid_d = valid_d & ~rs_kill;
    if (rs_ok) valid_d[rs_id] = 1'b0;
    if (ck_take) valid_d[ck_id] = 1'b1;
    if (flush) valid_d = '0;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      tag_q <= {REG_CNT{TAG_FREE}};
      snap_q <= {(NUM_CKPT*REG_CNT){TAG_FREE}};
      valid_q <= '0;
    end else begin
      data_q <= data_d;
      tag_q <= tag_d;
      snap_q <= snap_d;
      valid_q <= valid_d;
    end
  end
endmodule
